// File: rtl/alu_secuencial_ctrl_pkg.sv
// Shared definitions for the sequential ALU controller: nibble width, opcodes,
// FSM states and the shift-add multiply iteration count.
package alu_secuencial_ctrl_pkg;

   localparam int W         = 4;
   localparam int MUL_ITERS = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOW  = 3'd1,
      S_HIGH = 3'd2,
      S_MUL  = 3'd3,
      S_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/alu_secuencial_ctrl_sumador.sv
// Combinational W-bit adder/subtractor shared by every operation of the controller.
// modo=0: R = A + B + cin_bin, cout_bout = carry; modo=1: R = A - B - cin_bin, cout_bout = borrow.
module sumador_restador_4b #(
   parameter int W = 4
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         modo,
   input  logic         cin_bin,
   output logic [W-1:0] R,
   output logic         cout_bout
);

   logic [W:0] ext;

   // One extra bit captures the carry, or the wrapped sign bit that signals a borrow.
   always_comb begin
      ext = '0;
      if (!modo) begin
         ext = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin_bin};
      end else begin
         ext = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, cin_bin};
      end
   end

   assign R         = ext[W-1:0];
   assign cout_bout = ext[W];

endmodule

// File: rtl/alu_secuencial_ctrl.sv
// Multi-cycle controller that time-shares one nibble adder/subtractor to perform
// 8-bit ADD/SUB (two nibble passes) and 4x4 unsigned MUL (four shift-add steps).
module alu_secuencial_ctrl
   import alu_secuencial_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [2*W-1:0] a,
   input  logic [2*W-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] resultado,
   output logic           flag,
   output logic           error
);

   state_e         state_q;
   op_e            op_q;
   logic [2*W-1:0] a_q, b_q, res_q;
   logic [W-1:0]   hi_q, lo_q;
   logic           carry_q, busy_q, done_q, flag_q, error_q;
   logic [1:0]     cnt_q;

   logic [W-1:0]   u_a, u_b, u_r;
   logic           u_modo, u_cin, u_cout;
   logic [W-1:0]   mul_ph_d, mul_pl_d;

   sumador_restador_4b #(.W(W)) u_sumres (
      .A         (u_a),
      .B         (u_b),
      .modo      (u_modo),
      .cin_bin   (u_cin),
      .R         (u_r),
      .cout_bout (u_cout)
   );

   // In MUL, hi_q/lo_q act as the partial product P_H/P_L; adding zero when
   // P_L[0]=0 keeps a single datapath for both branches of the iteration.
   always_comb begin
      u_a    = '0;
      u_b    = '0;
      u_modo = 1'b0;
      u_cin  = 1'b0;
      case (state_q)
         S_LOW: begin
            u_a    = a_q[W-1:0];
            u_b    = b_q[W-1:0];
            u_modo = (op_q == OP_SUB);
         end
         S_HIGH: begin
            u_a    = a_q[2*W-1:W];
            u_b    = b_q[2*W-1:W];
            u_modo = (op_q == OP_SUB);
            u_cin  = carry_q;
         end
         S_MUL: begin
            u_a = hi_q;
            u_b = lo_q[0] ? a_q[W-1:0] : '0;
         end
         default: ;
      endcase
   end

   assign mul_ph_d = {u_cout, u_r[W-1:1]};
   assign mul_pl_d = {u_r[0], lo_q[W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         flag_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q    <= op_e'(op);
                  a_q     <= a;
                  b_q     <= b;
                  error_q <= 1'b0;
                  hi_q    <= '0;
                  lo_q    <= b[W-1:0];
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  case (op_e'(op))
                     OP_ADD, OP_SUB: begin
                        state_q <= S_LOW;
                        busy_q  <= 1'b1;
                     end
                     OP_MUL: begin
                        state_q <= S_MUL;
                        busy_q  <= 1'b1;
                     end
                     default: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        res_q   <= '0;
                        flag_q  <= 1'b0;
                        error_q <= 1'b1;
                     end
                  endcase
               end
            end
            S_LOW: begin
               lo_q    <= u_r;
               carry_q <= u_cout;
               state_q <= S_HIGH;
            end
            S_HIGH: begin
               res_q   <= {u_r, lo_q};
               flag_q  <= u_cout;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            S_MUL: begin
               hi_q  <= mul_ph_d;
               lo_q  <= mul_pl_d;
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'(MUL_ITERS - 1)) begin
                  res_q   <= {mul_ph_d, mul_pl_d};
                  flag_q  <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign resultado = res_q;
   assign flag      = flag_q;
   assign error     = error_q;

endmodule
